// File: rtl/uart_apb_arb.sv
// Two-requester arbiter in front of an APB master port toward the UART register block.
// Define UART_ARB_FIXED_PRIO_EN for fixed priority (requester 0 wins ties) instead of round-robin.
module uart_apb_arb #(
    parameter int unsigned DATA_W = 32
) (
    input  logic              pClk,
    input  logic              pReset,
    input  logic              req0,
    input  logic              req1,
    input  logic              we0,
    input  logic              we1,
    input  logic [DATA_W-1:0] addr0,
    input  logic [DATA_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata0,
    input  logic [DATA_W-1:0] wdata1,
    output logic              done0,
    output logic              done1,
    output logic [DATA_W-1:0] rdata0,
    output logic [DATA_W-1:0] rdata1,
    output logic              busy,
    output logic              pSel,
    output logic              pEnable,
    output logic              pWrite,
    output logic [DATA_W-1:0] pAddr,
    output logic [DATA_W-1:0] pWdata,
    input  logic [DATA_W-1:0] pReadData
);

    typedef enum logic [1:0] {StIdle, StSetup, StAccess, StDone} state_e;

    state_e            state_q, state_d;
    logic              gnt_q, gnt_d;
    logic              psel_q, psel_d;
    logic              penable_q, penable_d;
    logic              pwrite_q, pwrite_d;
    logic [DATA_W-1:0] paddr_q, paddr_d;
    logic [DATA_W-1:0] pwdata_q, pwdata_d;
    logic              done0_q, done0_d;
    logic              done1_q, done1_d;
    logic [DATA_W-1:0] rdata0_q, rdata0_d;
    logic [DATA_W-1:0] rdata1_q, rdata1_d;
    logic              win;

    // gnt_q is updated only on entry to SETUP, so it doubles as the last-served pointer.
    always_comb begin
`ifdef UART_ARB_FIXED_PRIO_EN
        win = !req0;
`else
        win = (req0 && req1) ? !gnt_q : !req0;
`endif
    end

    always_comb begin
        state_d   = state_q;
        gnt_d     = gnt_q;
        psel_d    = psel_q;
        penable_d = penable_q;
        pwrite_d  = pwrite_q;
        paddr_d   = paddr_q;
        pwdata_d  = pwdata_q;
        done0_d   = 1'b0;
        done1_d   = 1'b0;
        rdata0_d  = rdata0_q;
        rdata1_d  = rdata1_q;
        unique case (state_q)
            StIdle: begin
                if (req0 || req1) begin
                    state_d  = StSetup;
                    gnt_d    = win;
                    psel_d   = 1'b1;
                    pwrite_d = win ? we1 : we0;
                    paddr_d  = win ? addr1 : addr0;
                    pwdata_d = win ? wdata1 : wdata0;
                end
            end
            StSetup: begin
                state_d   = StAccess;
                penable_d = 1'b1;
            end
            StAccess: begin
                state_d   = StDone;
                psel_d    = 1'b0;
                penable_d = 1'b0;
                done0_d   = !gnt_q;
                done1_d   = gnt_q;
                if (!pwrite_q) begin
                    if (gnt_q) begin
                        rdata1_d = pReadData;
                    end else begin
                        rdata0_d = pReadData;
                    end
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d   = StIdle;
                psel_d    = 1'b0;
                penable_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge pClk or negedge pReset) begin
        if (!pReset) begin
            state_q   <= StIdle;
            gnt_q     <= 1'b1;
            psel_q    <= 1'b0;
            penable_q <= 1'b0;
            pwrite_q  <= 1'b0;
            paddr_q   <= '0;
            pwdata_q  <= '0;
            done0_q   <= 1'b0;
            done1_q   <= 1'b0;
            rdata0_q  <= '0;
            rdata1_q  <= '0;
        end else begin
            state_q   <= state_d;
            gnt_q     <= gnt_d;
            psel_q    <= psel_d;
            penable_q <= penable_d;
            pwrite_q  <= pwrite_d;
            paddr_q   <= paddr_d;
            pwdata_q  <= pwdata_d;
            done0_q   <= done0_d;
            done1_q   <= done1_d;
            rdata0_q  <= rdata0_d;
            rdata1_q  <= rdata1_d;
        end
    end

    assign busy    = (state_q != StIdle);
    assign pSel    = psel_q;
    assign pEnable = penable_q;
    assign pWrite  = pwrite_q;
    assign pAddr   = paddr_q;
    assign pWdata  = pwdata_q;
    assign done0   = done0_q;
    assign done1   = done1_q;
    assign rdata0  = rdata0_q;
    assign rdata1  = rdata1_q;

endmodule

// File: tb/tb_uart_apb_arb.sv
// Self-checking bench for uart_apb_arb: directed scenarios plus a randomized run
// against a transaction-level reference model.
module tb_uart_apb_arb;

    localparam int unsigned W = 32;

    logic         pClk = 1'b0;
    logic         pReset;
    logic         tb_req [2];
    logic         tb_we [2];
    logic [W-1:0] tb_addr [2];
    logic [W-1:0] tb_wdata [2];
    logic [W-1:0] pReadData;
    logic         done0, done1, busy, pSel, pEnable, pWrite;
    logic [W-1:0] rdata0, rdata1, pAddr, pWdata;

    int total = 0;
    int bad = 0;

    always #5 pClk = ~pClk;

    uart_apb_arb #(.DATA_W(W)) dut (
        .pClk      (pClk),
        .pReset    (pReset),
        .req0      (tb_req[0]),
        .req1      (tb_req[1]),
        .we0       (tb_we[0]),
        .we1       (tb_we[1]),
        .addr0     (tb_addr[0]),
        .addr1     (tb_addr[1]),
        .wdata0    (tb_wdata[0]),
        .wdata1    (tb_wdata[1]),
        .done0     (done0),
        .done1     (done1),
        .rdata0    (rdata0),
        .rdata1    (rdata1),
        .busy      (busy),
        .pSel      (pSel),
        .pEnable   (pEnable),
        .pWrite    (pWrite),
        .pAddr     (pAddr),
        .pWdata    (pWdata),
        .pReadData (pReadData)
    );

    task automatic clear_inputs();
        for (int i = 0; i < 2; i++) begin
            tb_req[i]   = 1'b0;
            tb_we[i]    = 1'b0;
            tb_addr[i]  = '0;
            tb_wdata[i] = '0;
        end
        pReadData = '0;
    endtask

    task automatic test_reset();
        pReset = 1'b0;
        clear_inputs();
        @(negedge pClk);
        @(negedge pClk);
        total++;
        if ({pSel, pEnable, pWrite, done0, done1, busy} !== 6'b0) begin
            bad++;
            $display("FAIL reset_ctl got=%b exp=000000", {pSel, pEnable, pWrite, done0, done1, busy});
        end
        total++;
        if (pAddr !== '0 || pWdata !== '0) begin
            bad++;
            $display("FAIL reset_bus got addr=%0h wdata=%0h exp=0,0", pAddr, pWdata);
        end
        total++;
        if (rdata0 !== '0 || rdata1 !== '0) begin
            bad++;
            $display("FAIL reset_rdata got r0=%0h r1=%0h exp=0,0", rdata0, rdata1);
        end
        pReset = 1'b1;
    endtask

    task automatic test_single_write();
        logic [5:0] exp_ctl [1:4];
        exp_ctl[1] = 6'b101001;
        exp_ctl[2] = 6'b111001;
        exp_ctl[3] = 6'b001101;
        exp_ctl[4] = 6'b001000;
        @(negedge pClk);
        tb_req[0] = 1'b1; tb_we[0] = 1'b1; tb_addr[0] = 0; tb_wdata[0] = 10;
        for (int k = 1; k <= 4; k++) begin
            @(negedge pClk);
            total++;
            if ({pSel, pEnable, pWrite, done0, done1, busy} !== exp_ctl[k]) begin
                bad++;
                $display("FAIL wr_ctl k=%0d got=%b exp=%b", k,
                         {pSel, pEnable, pWrite, done0, done1, busy}, exp_ctl[k]);
            end
            total++;
            if (pAddr !== 0 || pWdata !== 10) begin
                bad++;
                $display("FAIL wr_bus k=%0d got addr=%0d wdata=%0d exp=0,10", k, pAddr, pWdata);
            end
            if (k == 3) tb_req[0] = 1'b0;
        end
        total++;
        if (rdata0 !== 0) begin
            bad++;
            $display("FAIL wr_rdata0 got=%0d exp=0", rdata0);
        end
    endtask

    task automatic test_single_read();
        logic [5:0] exp_ctl [1:4];
        exp_ctl[1] = 6'b100001;
        exp_ctl[2] = 6'b110001;
        exp_ctl[3] = 6'b000011;
        exp_ctl[4] = 6'b000000;
        tb_req[1] = 1'b1; tb_we[1] = 1'b0; tb_addr[1] = 1; tb_wdata[1] = 0;
        pReadData = 0;
        for (int k = 1; k <= 4; k++) begin
            @(negedge pClk);
            total++;
            if ({pSel, pEnable, pWrite, done0, done1, busy} !== exp_ctl[k]) begin
                bad++;
                $display("FAIL rd_ctl k=%0d got=%b exp=%b", k,
                         {pSel, pEnable, pWrite, done0, done1, busy}, exp_ctl[k]);
            end
            total++;
            if (pAddr !== 1) begin
                bad++;
                $display("FAIL rd_addr k=%0d got=%0d exp=1", k, pAddr);
            end
            if (k == 1) pReadData = 20;
            if (k == 3) begin
                total++;
                if (rdata1 !== 20 || rdata0 !== 0) begin
                    bad++;
                    $display("FAIL rd_rdata got r1=%0d r0=%0d exp=20,0", rdata1, rdata0);
                end
                tb_req[1] = 1'b0;
            end
        end
    endtask

    task automatic test_mid_change();
        tb_req[0] = 1'b1; tb_we[0] = 1'b1; tb_addr[0] = 0; tb_wdata[0] = 7;
        for (int k = 1; k <= 4; k++) begin
            @(negedge pClk);
            total++;
            if (pAddr !== 0 || pWdata !== 7 || pWrite !== 1'b1) begin
                bad++;
                $display("FAIL mid_bus k=%0d got addr=%0d wdata=%0d we=%b exp=0,7,1",
                         k, pAddr, pWdata, pWrite);
            end
            total++;
            if (pEnable !== (k == 2) || done0 !== (k == 3)) begin
                bad++;
                $display("FAIL mid_ctl k=%0d got en=%b done0=%b exp=%b,%b",
                         k, pEnable, done0, (k == 2), (k == 3));
            end
            if (k == 1) begin
                tb_addr[0] = 1; tb_wdata[0] = 99; tb_we[0] = 1'b0;
            end
            if (k == 3) tb_req[0] = 1'b0;
        end
    endtask

    task automatic test_tie();
        int t;
        int w;
        logic exp_d0, exp_d1;
        pReset = 1'b0;
        clear_inputs();
        tb_req[0] = 1'b1; tb_we[0] = 1'b1; tb_addr[0] = 0; tb_wdata[0] = 32'h11;
        tb_req[1] = 1'b1; tb_we[1] = 1'b1; tb_addr[1] = 1; tb_wdata[1] = 32'h22;
        @(negedge pClk);
        @(negedge pClk);
        pReset = 1'b1;
        for (int k = 1; k <= 16; k++) begin
            @(negedge pClk);
            t = (k - 1) / 4;
`ifdef UART_ARB_FIXED_PRIO_EN
            w = 0;
`else
            w = t % 2;
`endif
            exp_d0 = (k % 4 == 3) && (w == 0);
            exp_d1 = (k % 4 == 3) && (w == 1);
            total++;
            if ({done0, done1} !== {exp_d0, exp_d1}) begin
                bad++;
                $display("FAIL tie_done k=%0d got=%b%b exp=%b%b", k, done0, done1, exp_d0, exp_d1);
            end
            if (k % 4 == 2) begin
                total++;
                if (pAddr !== W'(w)) begin
                    bad++;
                    $display("FAIL tie_grant k=%0d got addr=%0d exp=%0d", k, pAddr, w);
                end
            end
            if (k == 16) begin
                tb_req[0] = 1'b0;
                tb_req[1] = 1'b0;
            end
        end
    endtask

    task automatic test_reset_abort();
        @(negedge pClk);
        tb_req[0] = 1'b1; tb_we[0] = 1'b0; tb_addr[0] = 1; pReadData = 55;
        @(negedge pClk);
        @(negedge pClk);
        total++;
        if (pSel !== 1'b1 || pEnable !== 1'b1) begin
            bad++;
            $display("FAIL abort_access got sel=%b en=%b exp=1,1", pSel, pEnable);
        end
        pReset = 1'b0;
        #1;
        total++;
        if (pSel !== 1'b0 || pEnable !== 1'b0 || busy !== 1'b0) begin
            bad++;
            $display("FAIL abort_async got sel=%b en=%b busy=%b exp=0,0,0", pSel, pEnable, busy);
        end
        @(negedge pClk);
        total++;
        if (done0 !== 1'b0 || done1 !== 1'b0 || rdata0 !== 0) begin
            bad++;
            $display("FAIL abort_nodone got d0=%b d1=%b r0=%0d exp=0,0,0", done0, done1, rdata0);
        end
        pReset = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            @(negedge pClk);
            total++;
            if (done0 !== (k == 3) || done1 !== 1'b0) begin
                bad++;
                $display("FAIL abort_resume k=%0d got d0=%b d1=%b exp=%b,0", k, done0, done1, (k == 3));
            end
            if (k == 3) begin
                total++;
                if (rdata0 !== 55) begin
                    bad++;
                    $display("FAIL abort_rdata got=%0d exp=55", rdata0);
                end
                tb_req[0] = 1'b0;
            end
        end
    endtask

    // Reference model: cnt counts cycles since a grant (0 = idle, 3 = done cycle).
    task automatic test_random();
        int cnt;
        int m_gnt;
        int last;
        int w;
        logic         m_we;
        logic [W-1:0] m_addr, m_wdata;
        logic [W-1:0] m_rdata [2];
        logic [5:0]   exp_ctl;
        pReset = 1'b0;
        clear_inputs();
        @(negedge pClk);
        pReset = 1'b1;
        cnt = 0; m_gnt = 0; last = 1;
        m_we = 1'b0; m_addr = '0; m_wdata = '0;
        m_rdata[0] = '0; m_rdata[1] = '0;
        for (int c = 0; c < 2000; c++) begin
            @(negedge pClk);
            exp_ctl = {(cnt == 1 || cnt == 2), (cnt == 2), m_we,
                       (cnt == 3 && m_gnt == 0), (cnt == 3 && m_gnt == 1), (cnt != 0)};
            total++;
            if ({pSel, pEnable, pWrite, done0, done1, busy} !== exp_ctl) begin
                bad++;
                $display("FAIL rnd_ctl c=%0d got=%b exp=%b", c,
                         {pSel, pEnable, pWrite, done0, done1, busy}, exp_ctl);
            end
            total++;
            if (pAddr !== m_addr || pWdata !== m_wdata) begin
                bad++;
                $display("FAIL rnd_bus c=%0d got=%0h,%0h exp=%0h,%0h", c, pAddr, pWdata, m_addr, m_wdata);
            end
            total++;
            if (rdata0 !== m_rdata[0] || rdata1 !== m_rdata[1]) begin
                bad++;
                $display("FAIL rnd_rdata c=%0d got=%0h,%0h exp=%0h,%0h", c, rdata0, rdata1,
                         m_rdata[0], m_rdata[1]);
            end
            total++;
            if ((done0 && done1) || (pEnable && !pSel)) begin
                bad++;
                $display("FAIL rnd_protocol c=%0d got d0=%b d1=%b en=%b sel=%b", c, done0, done1,
                         pEnable, pSel);
            end
            for (int i = 0; i < 2; i++) begin
                if (tb_req[i] && cnt == 3 && m_gnt == i) begin
                    tb_req[i] = 1'b0;
                end else if (tb_req[i] && !(cnt != 0 && m_gnt == i) && $urandom_range(0, 15) == 0) begin
                    tb_req[i] = 1'b0;
                end else if (!tb_req[i] && $urandom_range(0, 3) == 0) begin
                    tb_req[i] = 1'b1;
                end
                if ($urandom_range(0, 3) == 0) begin
                    tb_we[i]    = 1'($urandom_range(0, 1));
                    tb_addr[i]  = W'($urandom_range(0, 1));
                    tb_wdata[i] = W'($urandom);
                end
            end
            pReadData = W'($urandom);
            case (cnt)
                0: begin
                    if (tb_req[0] || tb_req[1]) begin
                        if (tb_req[0] && tb_req[1]) begin
`ifdef UART_ARB_FIXED_PRIO_EN
                            w = 0;
`else
                            w = (last == 0) ? 1 : 0;
`endif
                        end else begin
                            w = tb_req[1] ? 1 : 0;
                        end
                        m_gnt   = w;
                        last    = w;
                        m_we    = tb_we[w];
                        m_addr  = tb_addr[w];
                        m_wdata = tb_wdata[w];
                        cnt     = 1;
                    end
                end
                1: cnt = 2;
                2: begin
                    if (!m_we) m_rdata[m_gnt] = pReadData;
                    cnt = 3;
                end
                default: cnt = 0;
            endcase
        end
        clear_inputs();
    endtask

    initial begin
        pReset = 1'b0;
        clear_inputs();
        test_reset();
        test_single_write();
        test_single_read();
        test_mid_change();
        test_tie();
        test_reset_abort();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
